// File: rtl/cpu_mem_bridge.sv
// Bridges the CPU instruction and data channels onto one single-port SRAM.
// Requests are served one at a time, and data requests take priority over fetches.
module cpu_mem_bridge #(
    parameter int ADDR_WIDTH  = 14,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           PC,
    input  logic                  Inst_Req_Valid,
    output logic                  Inst_Req_Ready,
    output logic [31:0]           Instruction,
    output logic                  Inst_Valid,
    input  logic                  Inst_Ready,
    input  logic [31:0]           Address,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [31:0]           Write_data,
    input  logic [3:0]            Write_strb,
    output logic                  Mem_Req_Ready,
    output logic [31:0]           Read_data,
    output logic                  Read_data_Valid,
    input  logic                  Read_data_Ready,
    output logic                  sram_en,
    output logic [3:0]            sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ACCESS  = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_IRESP   = 3'd4;
    localparam logic [2:0] S_DRESP   = 3'd5;

    localparam logic [1:0] REQ_WRITE = 2'd0;
    localparam logic [1:0] REQ_INST  = 2'd1;
    localparam logic [1:0] REQ_DATA  = 2'd2;

    // The counter runs WAIT_LOAD..0, giving exactly WAIT_CYCLES cycles in S_WAIT.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [2:0]            state;
    logic [2:0]            state_next;
    logic [3:0]            wait_cnt;
    logic [1:0]            req_kind;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [31:0]           resp_q;
    logic                  is_idle;
    logic                  data_req;
    logic                  unused_bits;

    assign is_idle        = (state == S_IDLE);
    assign data_req       = MemRead | MemWrite;
    assign Mem_Req_Ready  = rst_n & is_idle & data_req;
    assign Inst_Req_Ready = rst_n & is_idle & Inst_Req_Valid & ~data_req;

    assign sram_en    = (state == S_ACCESS);
    assign sram_we    = (state == S_ACCESS && req_kind == REQ_WRITE) ? wstrb_q : 4'b0000;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

    assign Inst_Valid      = (state == S_IRESP);
    assign Read_data_Valid = (state == S_DRESP);
    assign Instruction     = resp_q;
    assign Read_data       = resp_q;

    assign unused_bits = ^{PC[31:ADDR_WIDTH+2], PC[1:0], Address[31:ADDR_WIDTH+2], Address[1:0]};

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (Mem_Req_Ready || Inst_Req_Ready) state_next = S_ACCESS;
            S_ACCESS:  state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_CAPTURE;
            S_WAIT:    if (wait_cnt == 4'd0) state_next = S_CAPTURE;
            S_CAPTURE: begin
                case (req_kind)
                    REQ_INST: state_next = S_IRESP;
                    REQ_DATA: state_next = S_DRESP;
                    default:  state_next = S_IDLE;
                endcase
            end
            S_IRESP:   if (Inst_Ready) state_next = S_IDLE;
            S_DRESP:   if (Read_data_Ready) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            req_kind <= REQ_WRITE;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            wstrb_q  <= 4'd0;
            resp_q   <= 32'd0;
        end else begin
            state <= state_next;
            if (state == S_ACCESS) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == S_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            // A simultaneous read and write is treated as a write; the read is dropped.
            if (Mem_Req_Ready) begin
                req_kind <= MemWrite ? REQ_WRITE : REQ_DATA;
                addr_q   <= Address[ADDR_WIDTH+1:2];
                wdata_q  <= Write_data;
                wstrb_q  <= Write_strb;
            end else if (Inst_Req_Ready) begin
                req_kind <= REQ_INST;
                addr_q   <= PC[ADDR_WIDTH+1:2];
                wdata_q  <= Write_data;
                wstrb_q  <= Write_strb;
            end
            if (state == S_CAPTURE && req_kind != REQ_WRITE) begin
                resp_q <= sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Scoreboard bench for cpu_mem_bridge with a behavioural SRAM model.
module tb_cpu_mem_bridge;

    localparam int AW = 14;
    localparam int W  = 2;

    logic          clk;
    logic          rst_n;
    logic [31:0]   PC;
    logic          Inst_Req_Valid;
    logic          Inst_Req_Ready;
    logic [31:0]   Instruction;
    logic          Inst_Valid;
    logic          Inst_Ready;
    logic [31:0]   Address;
    logic          MemWrite;
    logic          MemRead;
    logic [31:0]   Write_data;
    logic [3:0]    Write_strb;
    logic          Mem_Req_Ready;
    logic [31:0]   Read_data;
    logic          Read_data_Valid;
    logic          Read_data_Ready;
    logic          sram_en;
    logic [3:0]    sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [31:0]   pre_data;

    int            n_checks;
    int            n_fail;
    logic [31:0]   inst_q[$];
    logic [31:0]   data_q[$];
    logic          prev_rvalid;
    logic [31:0]   prev_rdata;

    cpu_mem_bridge #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
        .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
        .Address(Address), .MemWrite(MemWrite), .MemRead(MemRead),
        .Write_data(Write_data), .Write_strb(Write_strb), .Mem_Req_Ready(Mem_Req_Ready),
        .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: read data appears the cycle after an enabled access and holds.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (sram_en) begin
            sram_rdata <= mem[sram_addr];
            for (int b = 0; b < 4; b++) begin
                if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic actual, input logic expected);
        check_output(name, {31'd0, actual}, {31'd0, expected});
    endtask

    // Pops the expected response on every completed handshake, independent of stimulus.
    always @(negedge clk) begin
        if (rst_n) begin
            if (Inst_Valid && Inst_Ready) begin
                if (inst_q.size() == 0) check_output("inst_unexpected", Instruction, 32'hFFFF_FFFF ^ Instruction);
                else check_output("inst_data", Instruction, inst_q.pop_front());
            end
            if (Read_data_Valid && Read_data_Ready) begin
                if (data_q.size() == 0) check_output("rdata_unexpected", Read_data, 32'hFFFF_FFFF ^ Read_data);
                else check_output("rdata", Read_data, data_q.pop_front());
            end
            if (prev_rvalid && Read_data_Valid) check_output("rdata_stable", Read_data, prev_rdata);
        end
        prev_rvalid <= rst_n & Read_data_Valid;
        prev_rdata  <= Read_data;
    end

    task automatic preload(input logic [AW-1:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_addr = addr; pre_data = data;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic apply_stimulus(input logic iv, input logic [31:0] pc, input logic rd, input logic wr,
                                  input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] strb);
        @(posedge clk); #1;
        Inst_Req_Valid = iv; PC = pc; MemRead = rd; MemWrite = wr;
        Address = addr; Write_data = wd; Write_strb = strb;
    endtask

    // Entered at the sample point of the accept cycle (cycle 0).
    task automatic fetch_tail(input logic [AW-1:0] exp_addr, input logic [31:0] exp_data);
        inst_q.push_back(exp_data);
        @(posedge clk); #1;
        Inst_Req_Valid = 1'b0;
        @(negedge clk);
        check_bit("fetch_sram_en", sram_en, 1'b1);
        check_output("fetch_sram_addr", {18'd0, sram_addr}, {18'd0, exp_addr});
        check_output("fetch_sram_we", {28'd0, sram_we}, 32'd0);
        for (int c = 2; c <= 3 + W; c++) begin
            @(negedge clk);
            check_bit("inst_valid_timing", Inst_Valid, c == 3 + W);
        end
        @(negedge clk);
        check_bit("inst_valid_one_cycle", Inst_Valid, 1'b0);
    endtask

    task automatic load_tail(input logic [AW-1:0] exp_addr, input logic [31:0] exp_data, input int hold);
        data_q.push_back(exp_data);
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        @(negedge clk);
        check_bit("load_sram_en", sram_en, 1'b1);
        check_output("load_sram_addr", {18'd0, sram_addr}, {18'd0, exp_addr});
        check_output("load_sram_we", {28'd0, sram_we}, 32'd0);
        check_bit("inst_ready_busy", Inst_Req_Ready, 1'b0);
        for (int c = 2; c <= 3 + W; c++) begin
            @(negedge clk);
            check_bit("rvalid_timing", Read_data_Valid, c == 3 + W);
            check_bit("inst_ready_busy", Inst_Req_Ready, 1'b0);
        end
        if (hold > 0) begin
            for (int k = 1; k < hold; k++) begin
                @(negedge clk);
                check_bit("rvalid_held", Read_data_Valid, 1'b1);
            end
            @(posedge clk); #1;
            Read_data_Ready = 1'b1;
            @(negedge clk);
            check_bit("rvalid_handshake", Read_data_Valid, 1'b1);
        end
        @(negedge clk);
        check_bit("rvalid_drop", Read_data_Valid, 1'b0);
    endtask

    task automatic issue_fetch(input logic [31:0] pc, input logic [AW-1:0] exp_addr, input logic [31:0] exp_data);
        apply_stimulus(1'b1, pc, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        check_bit("inst_req_ready", Inst_Req_Ready, 1'b1);
        fetch_tail(exp_addr, exp_data);
    endtask

    task automatic issue_load(input logic [31:0] addr, input logic [AW-1:0] exp_addr,
                              input logic [31:0] exp_data, input int hold);
        apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0, addr, 32'd0, 4'd0);
        Read_data_Ready = (hold == 0);
        @(negedge clk);
        check_bit("load_req_ready", Mem_Req_Ready, 1'b1);
        load_tail(exp_addr, exp_data, hold);
    endtask

    task automatic issue_store(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] strb,
                               input logic also_read, input logic [AW-1:0] exp_addr);
        apply_stimulus(1'b0, 32'd0, also_read, 1'b1, addr, wd, strb);
        @(negedge clk);
        check_bit("store_req_ready", Mem_Req_Ready, 1'b1);
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        @(negedge clk);
        check_bit("store_sram_en", sram_en, 1'b1);
        check_output("store_sram_we", {28'd0, sram_we}, {28'd0, strb});
        check_output("store_sram_addr", {18'd0, sram_addr}, {18'd0, exp_addr});
        check_output("store_sram_wdata", sram_wdata, wd);
        @(negedge clk);
        check_output("store_we_one_cycle", {28'd0, sram_we}, 32'd0);
        check_bit("store_en_one_cycle", sram_en, 1'b0);
        for (int c = 3; c <= 2 + W; c++) begin
            @(negedge clk);
            check_bit("store_no_response", Read_data_Valid, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = 32'd0;
        PC = 32'd0; Inst_Req_Valid = 1'b0; Inst_Ready = 1'b1;
        Address = 32'd0; MemWrite = 1'b0; MemRead = 1'b0; Write_data = 32'd0; Write_strb = 4'd0;
        Read_data_Ready = 1'b1;

        preload(14'd5,    32'hDEAD_BEEF);
        preload(14'h40,   32'h1111_1111);
        preload(14'h80,   32'hCAFE_F00D);
        preload(14'h10,   32'h1000_0010);
        preload(14'd9,    32'hA5A5_0009);
        preload(14'd6,    32'h6666_6666);
        preload(14'd7,    32'h0BAD_F00D);
        preload(14'd2,    32'h1234_5678);

        @(negedge clk);
        check_bit("rst_inst_valid", Inst_Valid, 1'b0);
        check_bit("rst_rvalid", Read_data_Valid, 1'b0);
        check_bit("rst_sram_en", sram_en, 1'b0);
        check_output("rst_sram_we", {28'd0, sram_we}, 32'd0);
        check_output("rst_instruction", Instruction, 32'd0);
        check_output("rst_read_data", Read_data, 32'd0);
        check_output("rst_sram_addr", {18'd0, sram_addr}, 32'd0);
        check_output("rst_sram_wdata", sram_wdata, 32'd0);
        Inst_Req_Valid = 1'b1; MemRead = 1'b1;
        #1;
        check_bit("rst_inst_req_ready", Inst_Req_Ready, 1'b0);
        check_bit("rst_mem_req_ready", Mem_Req_Ready, 1'b0);
        Inst_Req_Valid = 1'b0; MemRead = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        issue_fetch(32'h0000_0014, 14'd5, 32'hDEAD_BEEF);

        // Byte lane 2 of word 0x40 becomes 0xAB.
        issue_store(32'h0000_0102, 32'h00AB_0000, 4'b0100, 1'b0, 14'h40);
        issue_load(32'h0000_0100, 14'h40, 32'h11AB_1111, 0);

        apply_stimulus(1'b1, 32'h0000_0024, 1'b1, 1'b0, 32'h0000_0040, 32'd0, 4'd0);
        @(negedge clk);
        check_bit("prio_mem_ready", Mem_Req_Ready, 1'b1);
        check_bit("prio_inst_ready", Inst_Req_Ready, 1'b0);
        load_tail(14'h10, 32'h1000_0010, 0);
        check_bit("prio_inst_after", Inst_Req_Ready, 1'b1);
        fetch_tail(14'd9, 32'hA5A5_0009);

        issue_load(32'h0000_0200, 14'h80, 32'hCAFE_F00D, 7);

        issue_store(32'h0000_0200, 32'hFFFF_FFFF, 4'b0000, 1'b0, 14'h80);
        issue_load(32'h0000_0200, 14'h80, 32'hCAFE_F00D, 0);

        issue_store(32'h0000_0240, 32'h55AA_55AA, 4'b1111, 1'b1, 14'h90);
        issue_load(32'h0000_0240, 14'h90, 32'h55AA_55AA, 0);

        // Abort a fetch while it sits in the wait state.
        apply_stimulus(1'b1, 32'h0000_0018, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        check_bit("abort_inst_ready", Inst_Req_Ready, 1'b1);
        @(posedge clk); #1;
        Inst_Req_Valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0; Inst_Req_Valid = 1'b1; MemRead = 1'b1;
        #1;
        check_bit("abort_inst_valid", Inst_Valid, 1'b0);
        check_bit("abort_rvalid", Read_data_Valid, 1'b0);
        check_bit("abort_sram_en", sram_en, 1'b0);
        check_bit("abort_inst_ready_low", Inst_Req_Ready, 1'b0);
        check_bit("abort_mem_ready_low", Mem_Req_Ready, 1'b0);
        check_output("abort_instruction", Instruction, 32'd0);
        check_output("abort_sram_addr", {18'd0, sram_addr}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; MemRead = 1'b0; PC = 32'h0000_001C;
        #1;
        check_bit("abort_idle_after", Inst_Req_Ready, 1'b1);
        fetch_tail(14'd7, 32'h0BAD_F00D);

        issue_fetch(32'h0001_0008, 14'd2, 32'h1234_5678);

        repeat (3) @(negedge clk);
        check_output("queues_drained", 32'(inst_q.size() + data_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
